bus_xfer_ctrl: RTL
==================

Name: bus_xfer_ctrl

Overview:
- Sequences register-to-register moves on the shared 16-bit tristate bus.
- Drives one-hot ENABLE and LOAD vectors to NREG bus registers.
- Arbitrates round-robin between NREQ requesters; grants one transfer at a time, so at most one register ever drives the bus.

Parameters:
- NREG, 8: number of bus registers controlled; 2..16.
- NREQ, 2: number of requesters; 1..4.
- IDXW, 3: register index width; must hold NREG-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- req  input  NREQ  per-requester transfer request, level; held until ack.
- src_idx  input  NREQ*IDXW  flattened source register index; requester i occupies bits [i*IDXW +: IDXW].
- dst_idx  input  NREQ*IDXW  flattened destination register index, same packing.
- ack  output  NREQ  one-cycle pulse to the requester whose transfer completed.
- enable  output  NREG  one-hot or zero; drives each register's ENABLE.
- load  output  NREG  one-hot or zero; drives each register's LOAD.
- busy  output  1  high while a transfer is in flight (any state except IDLE).
- err  output  1  one-cycle pulse on a rejected command; only with XFER_CHECK_EN.

Behaviour:
- Reset: asynchronous on rst_n low; all outputs 0; FSM to IDLE; round-robin pointer to 0; latched src/dst to 0.
- Reset mid-transfer: enable and load drop to 0 immediately (asynchronous); no ack is issued.
- FSM states: IDLE, DRIVE, LATCH, RELEASE.
- IDLE, any req bit high:
  - Grant the first requester at or after rr_ptr, searching upward with wrap.
  - Latch that requester's src/dst indices and grant id.
  - Go to DRIVE.
- IDLE, no req: stay; outputs 0.
- DRIVE (1 cycle): enable[src]=1, load=0. Bus settles from the source register. Next state LATCH.
- LATCH (1 cycle): enable[src]=1, load[dst]=1. Destination captures the bus. Next state RELEASE.
- RELEASE (1 cycle):
  - enable[src]=1, load=0, so LOAD falls while the bus is still driven.
  - ack[grant]=1.
  - rr_ptr <= grant+1, modulo NREQ.
  - Next state IDLE.
- Latency: req sampled in IDLE to ack is 3 cycles. Back-to-back transfers occupy 4 cycles each, including the IDLE cycle.
- Outputs enable, load and ack are registered, decoded from the FSM state and latched indices; no combinational path from req.
- Bus-contention invariant: enable has at most one bit high in every cycle; load is high only in LATCH.
- Requests are sampled only in IDLE; changes to src_idx/dst_idx mid-transfer are ignored.
- A requester must drop req in the cycle after ack, otherwise it is re-arbitrated as a new request.
- src==dst without the check: performed normally; the value is unchanged.
- Index >= NREG without the check: no enable/load bit asserts for that index. The transfer still runs 3 cycles and acks.
- NREQ=1: the arbiter degenerates to a pass-through; rr_ptr stays 0.

Optional Feature:
- Macro: XFER_CHECK_EN.
- Defined:
  - In IDLE, a granted command with src==dst, src>=NREG or dst>=NREG is rejected.
  - err=1 and ack[grant]=1 in the next cycle; no enable/load assert; rr_ptr advances; FSM returns to IDLE.
  - Rejected command latency is 1 cycle.
- Undefined: err is tied to 0 and commands are never rejected (behaviour as above).

Decomposition:
- Shared package bus_ctrl_pkg:
  - FSM state encoding: IDLE=2'd0, DRIVE=2'd1, LATCH=2'd2, RELEASE=2'd3.
  - Default widths: BUS_W=16, IDX_W=3.
- Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant and grant index; purely combinational.
- The FSM and decode stay in bus_xfer_ctrl.

Test Plan:
- Reset: rst_n low with req=2'b11 -> enable=0, load=0, ack=0, busy=0. Asserting rst_n low during LATCH clears load the same cycle with no ack.
- Single move: req0 with src=2, dst=5; R2 preloaded with 16'hA5C3 -> enable=8'h04 for 3 cycles; load=8'h20 in cycle 2 only; ack=2'b01 in cycle 3; R5 reads 16'hA5C3.
- Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1; each ack arrives 4 cycles apart; enable is never more than one-hot (assertion).
- Chained moves: R1->R3 then R3->R7 -> R7 ends equal to the original R1; no cycle with both load and an enable change to a different source.
- Ignore late change: alter src_idx during DRIVE from 2 to 4 -> enable stays 8'h04.
- XFER_CHECK_EN: src=dst=3 -> err=1 and ack pulse 1 cycle after grant, enable=load=0 throughout. Without the macro, the same stimulus gives enable=8'h08 for 3 cycles and err=0.

Source files
------------

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and defaults for the bus transfer controller: FSM state encoding,
// default bus/index widths and a pointer-width helper.
package bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      LATCH   = 2'd2,
      RELEASE = 2'd3
   } xfer_state_e;

   localparam int BUS_W = 16;
   localparam int IDX_W = 3;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Handshake and register-control bundle between requesters, the transfer
// controller (master) and the bus registers / requesters (slave).
interface bus_xfer_ctrl_if #(
   parameter int NREG = 8,
   parameter int NREQ = 2,
   parameter int IDXW = 3
);
   logic [NREQ-1:0]      req;
   logic [NREQ*IDXW-1:0] src_idx;
   logic [NREQ*IDXW-1:0] dst_idx;
   logic [NREQ-1:0]      ack;
   logic [NREG-1:0]      enable;
   logic [NREG-1:0]      load;
   logic                 busy;
   logic                 err;

   modport master (
      input  req, src_idx, dst_idx,
      output ack, enable, load, busy, err
   );

   modport slave (
      output req, src_idx, dst_idx,
      input  ack, enable, load, busy, err
   );
endinterface

// File: rtl/bus_xfer_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// after ptr, searching upward with wrap.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PTRW = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PTRW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PTRW-1:0] gnt_idx
);

   always_comb begin
      logic found;
      int   cand;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr) + off) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = PTRW'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register move sequencer for the shared tristate bus.
// Optional command checking is enabled by defining XFER_CHECK_EN.
module bus_xfer_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int NREG = 8,
   parameter int NREQ = 2,
   parameter int IDXW = 3
) (
   input logic            clk,
   input logic            rst_n,
   bus_xfer_ctrl_if.master bus
);

   localparam int PTRW = ptr_w(NREQ);

   xfer_state_e     state_q, state_d;
   logic [IDXW-1:0] src_q, src_d;
   logic [IDXW-1:0] dst_q, dst_d;
   logic [PTRW-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
   logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
   logic [NREG-1:0] enable_q, enable_d;
   logic [NREG-1:0] load_q, load_d;
   logic [NREQ-1:0] ack_q, ack_d;
`ifdef XFER_CHECK_EN
   logic            err_q, err_d;
`endif

   logic [NREQ-1:0] arb_gnt;
   logic [PTRW-1:0] arb_idx;

   rr_arbiter #(
      .NREQ (NREQ),
      .PTRW (PTRW)
   ) u_arb (
      .req     (bus.req),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // Out-of-range indices decode to all zeros, so nothing drives or loads.
   function automatic logic [NREG-1:0] idx_dec(input logic [IDXW-1:0] idx);
      logic [NREG-1:0] oh;
      oh = '0;
      for (int i = 0; i < NREG; i++) begin
         if (int'(idx) == i) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] g);
      if (NREQ == 1 || int'(g) >= NREQ - 1) return '0;
      return PTRW'(int'(g) + 1);
   endfunction

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      gnt_d    = gnt_q;
      gnt_oh_d = gnt_oh_q;
      rr_ptr_d = rr_ptr_q;
      ack_d    = '0;
`ifdef XFER_CHECK_EN
      err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               src_d    = bus.src_idx[arb_idx*IDXW +: IDXW];
               dst_d    = bus.dst_idx[arb_idx*IDXW +: IDXW];
               gnt_d    = arb_idx;
               gnt_oh_d = arb_gnt;
`ifdef XFER_CHECK_EN
               if (src_d == dst_d || int'(src_d) >= NREG || int'(dst_d) >= NREG) begin
                  ack_d    = arb_gnt;
                  err_d    = 1'b1;
                  rr_ptr_d = next_ptr(arb_idx);
               end else begin
                  state_d = DRIVE;
               end
`else
               state_d = DRIVE;
`endif
            end
         end
         DRIVE:   state_d = LATCH;
         LATCH: begin
            // Ack is registered, so it is launched as RELEASE is entered.
            state_d = RELEASE;
            ack_d   = gnt_oh_q;
         end
         RELEASE: begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(gnt_q);
         end
         default: state_d = IDLE;
      endcase

      enable_d = (state_d != IDLE)  ? idx_dec(src_d) : '0;
      load_d   = (state_d == LATCH) ? idx_dec(dst_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         gnt_q    <= '0;
         gnt_oh_q <= '0;
         rr_ptr_q <= '0;
         enable_q <= '0;
         load_q   <= '0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         gnt_q    <= gnt_d;
         gnt_oh_q <= gnt_oh_d;
         rr_ptr_q <= rr_ptr_d;
         enable_q <= enable_d;
         load_q   <= load_d;
         ack_q    <= ack_d;
      end
   end

`ifdef XFER_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.enable = enable_q;
   assign bus.load   = load_q;
   assign bus.ack    = ack_q;
   assign bus.busy   = (state_q != IDLE);

endmodule
